aes_key_expander: RTL and testbench
===================================

Name: aes_key_expander

Overview:
- Parametrised successor to the AES-128 round-key generator; supports AES-128/192/256 via KEY_LENGTH.
- Expands the main key word-by-word and presents one 128-bit round key per enabled cycle, from round 0 to Nr.
- Adds load/valid/last handshake and round index for the cipher round controller; sits beside the AES round datapath.

Parameters:
- KEY_LENGTH, 128, main key width; only 128, 192 or 256 are legal, any other value is an elaboration error. Gives Nk = KEY_LENGTH/32 and Nr = 10/12/14.
- ROUND_W, 4, width of the Round output; must satisfy 2^ROUND_W > 14.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- M_KEY  in  KEY_LENGTH  main key; sampled only on Load.
- Load  in  1  start a new expansion.
- En  in  1  advance to the next round key.
- subKey_curr  out  128  current round key, words w[4r..4r+3], w[4r] in MSBs.
- Round  out  ROUND_W  index r of subKey_curr.
- Valid  out  1  subKey_curr is valid.
- Last  out  1  Valid and Round == Nr.

Behaviour:
- Reset (RST=0, asynchronous): subKey_curr=0, Round=0, Valid=0, Last=0. Internal word window, word counter and Rcon are cleared. Reset mid-expansion aborts the sequence.
- States: IDLE -> EXPAND -> DONE.
  - IDLE: Valid=0. Load=1 captures M_KEY.
  - Load: next edge gives Valid=1, Round=0, subKey_curr=M_KEY[KEY_LENGTH-1 -: 128], state=EXPAND. Load-to-valid latency is 1 cycle.
  - EXPAND: En=1 with Round<Nr gives Round+1 and the next 128-bit key on the next edge, so throughput is 1 round key per cycle. En=0 holds all outputs.
  - When Round reaches Nr: Last=1, state=DONE.
  - DONE: En is ignored and outputs hold until Load or reset.
- Load has priority over En in every state. Load during EXPAND or DONE restarts from round 0 with the new M_KEY, with the same 1-cycle latency.
- Expansion follows FIPS-197, w[i] = w[i-Nk] ^ temp:
  - i mod Nk == 0: temp = SubWord(RotWord(w[i-1])) ^ Rcon.
  - Nk==8 and i mod 8 == 4: temp = SubWord(w[i-1]).
  - Otherwise: temp = w[i-1].
- Four words are produced per advance as a combinational chain over the last Nk words.
  - At most one SubWord occurs in any 4-word group for every Nk, so exactly one 4-byte S-box instance is used.
  - Rcon starts at 8'h01 and updates by xtime (GF(2^8) doubling, reduction 8'h1B) on each use.
  - Rcon wraps 8'h80 -> 8'h1B; this is reachable only for Nk=4.
- AES-192 round 1 mixes key words 4..5 with generated words 6..7. AES-256 round 1 is key words 4..7, with no generation.
- En while Valid=0 (IDLE) is ignored.
- Load and En asserted in the same cycle: Load wins and En is discarded.

Optional Feature:
- Macro KEY_GEN_ROUND_CACHE_EN.
- When defined:
  - Adds ports Rd_Addr (in, ROUND_W), Rd_Key (out, 128) and Rd_Ok (out, 1).
  - Each round key presented on subKey_curr is written into an (Nr+1)x128 array.
  - Read latency is 1 cycle: Rd_Key = array[Rd_Addr].
  - Rd_Ok=1 only if that entry has been written since the last Load. Rd_Addr>Nr gives Rd_Ok=0 and Rd_Key=0.
  - Load and reset clear all written flags.
  - This lets the decryption path read keys in reverse order after DONE.
- When undefined: no extra ports or storage; behaviour is otherwise identical.

Test Plan:
- KEY_LENGTH=128, reset then Load M_KEY=2B7E151628AED2A6ABF7158809CF4F3C. Expect:
  - Round 0 equals the key.
  - After 1 En: A0FAFE1788542CB123A339392A6C7605.
  - After 10 En: D014F9A8C9EE2589E13F0CC8B6630CA6, with Last=1.
- KEY_LENGTH=192, Load 8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B, then 12 En. Expect Round=12 and subKey_curr=E98BA06F448C773C8ECC720401002202, with Last=1.
- KEY_LENGTH=256, Load 603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4. Expect:
  - Round 1 = 1F352C073B6108D72D9810A30914DFF4.
  - Round 14 = FE4890D1E6188D0B046DF344706C631E.
- En gaps and DONE hold (128-bit key): toggle En 1,0,0,1 and check outputs hold on the En=0 cycles. After Last, apply 3 more En and check Round stays 10 and the key is unchanged.
- Load mid-expansion and reset mid-expansion:
  - At Round=5, apply Load with En=1 and a new key. Expect Round=0 and the new key next cycle.
  - Drop RST mid-cycle at Round=3. Expect all outputs 0 immediately, without waiting for a clock edge.
- Cache (macro defined, 128-bit key): after DONE, read Rd_Addr 10 down to 0. Expect the stored round keys with Rd_Ok=1, then:
  - Rd_Addr=11 gives Rd_Ok=0.
  - Reading after a new Load at Round=0 gives Rd_Ok=0 for address 1.

Source files
------------

// File: rtl/aes_key_expander.sv
// rtl/aes_key_expander.sv - AES-128/192/256 key expander, one 128-bit round key per enabled cycle
// Optional macro KEY_GEN_ROUND_CACHE_EN adds an (Nr+1)-entry round-key cache with a read port.
module aes_key_expander #(
   parameter int KEY_LENGTH = 128,
   parameter int ROUND_W    = 4
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [KEY_LENGTH-1:0] M_KEY,
   input  logic                  Load,
   input  logic                  En,
`ifdef KEY_GEN_ROUND_CACHE_EN
   input  logic [ROUND_W-1:0]    Rd_Addr,
   output logic [127:0]          Rd_Key,
   output logic                  Rd_Ok,
`endif
   output logic [127:0]          subKey_curr,
   output logic [ROUND_W-1:0]    Round,
   output logic                  Valid,
   output logic                  Last
);
   localparam int NK = KEY_LENGTH / 32;
   localparam int NR = NK + 6;

   generate
      if (KEY_LENGTH != 128 && KEY_LENGTH != 192 && KEY_LENGTH != 256) begin : g_bad_key_length
         $error("aes_key_expander: KEY_LENGTH must be 128, 192 or 256");
      end
      if (ROUND_W < 4) begin : g_bad_round_w
         $error("aes_key_expander: ROUND_W too narrow for round 14");
      end
   endgenerate

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int k = 1; k < 8; k++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

   state_t                r_state;
   logic [KEY_LENGTH-1:0] r_win;
   logic [127:0]          r_key;
   logic [ROUND_W-1:0]    r_round;
   logic                  r_valid;
   logic                  r_last;
   logic [2:0]            r_phase;
   logic [7:0]            r_rcon;

   logic [31:0]           w_win [0:NK-1];
   logic [31:0]           w_new [0:3];
   logic [31:0]           w_chain;
   logic [31:0]           w_sub_in;
   logic [31:0]           w_sub_out;
   logic [31:0]           w_temp;
   logic [1:0]            w_sub_j;
   logic                  w_sub_hit;
   logic                  w_rcon_use;
   logic                  w_adv;
   logic [KEY_LENGTH-1:0] w_win_next;
   logic [2:0]            w_phase_next;

   // Window holds w[4r .. 4r+Nk-1]; each advance appends four words and drops the oldest four.
   always_comb begin
      w_sub_hit  = 1'b0;
      w_rcon_use = 1'b0;
      w_sub_j    = 2'd0;
      for (int j = 0; j < NK; j++) w_win[j] = r_win[KEY_LENGTH-1-32*j -: 32];
      for (int j = 0; j < 4; j++) begin
         if ((int'(r_phase) + j) % NK == 0) begin
            w_sub_hit  = 1'b1;
            w_rcon_use = 1'b1;
            w_sub_j    = 2'(j);
         end else if (NK == 8 && (int'(r_phase) + j) % NK == 4) begin
            w_sub_hit = 1'b1;
            w_sub_j   = 2'(j);
         end
      end
      // Words before the SubWord position are plain XOR chains, so the S-box input has no loop
      w_chain  = w_win[NK-1];
      w_sub_in = w_win[NK-1];
      for (int j = 0; j < 4; j++) begin
         if (w_sub_j == 2'(j)) w_sub_in = w_chain;
         w_chain = w_win[j] ^ w_chain;
      end
      w_sub_out = sub_word(w_sub_in);
      w_temp    = w_rcon_use ? ({w_sub_out[23:0], w_sub_out[31:24]} ^ {r_rcon, 24'h000000})
                             : w_sub_out;
      w_chain = w_win[NK-1];
      for (int j = 0; j < 4; j++) begin
         w_new[j] = w_win[j] ^ ((w_sub_hit && w_sub_j == 2'(j)) ? w_temp : w_chain);
         w_chain  = w_new[j];
      end
      w_win_next   = (r_win << 128) | KEY_LENGTH'({w_new[0], w_new[1], w_new[2], w_new[3]});
      w_phase_next = 3'((int'(r_phase) + 4) % NK);
   end

   assign w_adv = !Load && (r_state == S_EXPAND) && En && (r_round < ROUND_W'(NR));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         r_win   <= '0;
         r_key   <= '0;
         r_round <= '0;
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_phase <= 3'd0;
         r_rcon  <= 8'h00;
      end else if (Load) begin
         r_state <= S_EXPAND;
         r_win   <= M_KEY;
         r_key   <= M_KEY[KEY_LENGTH-1 -: 128];
         r_round <= '0;
         r_valid <= 1'b1;
         r_last  <= 1'b0;
         r_phase <= 3'd0;
         r_rcon  <= 8'h01;
      end else if (w_adv) begin
         r_win   <= w_win_next;
         r_key   <= w_win_next[KEY_LENGTH-1 -: 128];
         r_round <= r_round + ROUND_W'(1);
         r_phase <= w_phase_next;
         if (w_rcon_use) r_rcon <= xtime(r_rcon);
         if (r_round == ROUND_W'(NR - 1)) begin
            r_last  <= 1'b1;
            r_state <= S_DONE;
         end
      end
   end

   assign subKey_curr = r_key;
   assign Round       = r_round;
   assign Valid       = r_valid;
   assign Last        = r_last;

`ifdef KEY_GEN_ROUND_CACHE_EN
   logic [127:0] r_cache [0:NR];
   logic [NR:0]  r_written;
   logic [127:0] r_rd_key;
   logic         r_rd_ok;

   always_ff @(posedge CLK) begin
      if (Load) r_cache[0] <= M_KEY[KEY_LENGTH-1 -: 128];
      else if (w_adv) r_cache[r_round + ROUND_W'(1)] <= w_win_next[KEY_LENGTH-1 -: 128];
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_written <= '0;
         r_rd_key  <= '0;
         r_rd_ok   <= 1'b0;
      end else begin
         if (Load) r_written <= (NR+1)'(1);
         else if (w_adv) r_written[r_round + ROUND_W'(1)] <= 1'b1;
         if (Rd_Addr <= ROUND_W'(NR)) begin
            r_rd_key <= r_cache[Rd_Addr];
            r_rd_ok  <= r_written[Rd_Addr];
         end else begin
            r_rd_key <= '0;
            r_rd_ok  <= 1'b0;
         end
      end
   end

   assign Rd_Key = r_rd_key;
   assign Rd_Ok  = r_rd_ok;
`endif

endmodule

// File: tb/tb_aes_key_expander.sv
// tb/tb_aes_key_expander.sv - directed bench for aes_key_expander with AES-128/192/256 instances
// Cache checks are compiled in when KEY_GEN_ROUND_CACHE_EN is defined.
module tb_aes_key_expander;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [127:0] k128;
   logic [191:0] k192;
   logic [255:0] k256;
   logic         ld128, en128, ld192, en192, ld256, en256;
   logic [127:0] sk128, sk192, sk256;
   logic [3:0]   rnd128, rnd192, rnd256;
   logic         v128, v192, v256, l128, l192, l256;

`ifdef KEY_GEN_ROUND_CACHE_EN
   logic [3:0]   rd_addr;
   logic [127:0] rd_key, rd_key192, rd_key256;
   logic         rd_ok, rd_ok192, rd_ok256;
`endif

   int vectors    = 0;
   int miscompares = 0;

   localparam logic [127:0] KEYA    = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
   localparam logic [127:0] KEYB    = 128'h000102030405060708090A0B0C0D0E0F;
   localparam logic [127:0] KEYB_R1 = 128'hD6AA74FDD2AF72FADAA678F1D6AB76FE;

   logic [127:0] rk128 [0:10] = '{
      128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'hA0FAFE1788542CB123A339392A6C7605,
      128'hF2C295F27A96B9435935807A7359F67F, 128'h3D80477D4716FE3E1E237E446D7A883B,
      128'hEF44A541A8525B7FB671253BDB0BAD00, 128'hD4D1C6F87C839D87CAF2B8BC11F915BC,
      128'h6D88A37A110B3EFDDBF98641CA0093FD, 128'h4E54F70E5F5FC9F384A64FB24EA6DC4F,
      128'hEAD27321B58DBAD2312BF5607F8D292F, 128'hAC7766F319FADC2128D12941575C006E,
      128'hD014F9A8C9EE2589E13F0CC8B6630CA6};

   aes_key_expander #(.KEY_LENGTH(128), .ROUND_W(4)) u_dut128 (
      .CLK(clk), .RST(rst_n), .M_KEY(k128), .Load(ld128), .En(en128),
`ifdef KEY_GEN_ROUND_CACHE_EN
      .Rd_Addr(rd_addr), .Rd_Key(rd_key), .Rd_Ok(rd_ok),
`endif
      .subKey_curr(sk128), .Round(rnd128), .Valid(v128), .Last(l128));

   aes_key_expander #(.KEY_LENGTH(192), .ROUND_W(4)) u_dut192 (
      .CLK(clk), .RST(rst_n), .M_KEY(k192), .Load(ld192), .En(en192),
`ifdef KEY_GEN_ROUND_CACHE_EN
      .Rd_Addr(4'd0), .Rd_Key(rd_key192), .Rd_Ok(rd_ok192),
`endif
      .subKey_curr(sk192), .Round(rnd192), .Valid(v192), .Last(l192));

   aes_key_expander #(.KEY_LENGTH(256), .ROUND_W(4)) u_dut256 (
      .CLK(clk), .RST(rst_n), .M_KEY(k256), .Load(ld256), .En(en256),
`ifdef KEY_GEN_ROUND_CACHE_EN
      .Rd_Addr(4'd0), .Rd_Key(rd_key256), .Rd_Ok(rd_ok256),
`endif
      .subKey_curr(sk256), .Round(rnd256), .Valid(v256), .Last(l256));

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      k128 = '0; k192 = '0; k256 = '0;
      ld128 = 1'b0; en128 = 1'b0; ld192 = 1'b0; en192 = 1'b0; ld256 = 1'b0; en256 = 1'b0;
`ifdef KEY_GEN_ROUND_CACHE_EN
      rd_addr = 4'd0;
`endif
      tick();
      tick();
      chk("rst_key", sk128, 128'h0);
      chk("rst_round", 128'(rnd128), 128'd0);
      chk("rst_valid", 128'(v128), 128'd0);
      chk("rst_last", 128'(l128), 128'd0);

      rst_n = 1'b1;
      en128 = 1'b1;
      tick();
      en128 = 1'b0;
      chk("idle_en_valid", 128'(v128), 128'd0);
      chk("idle_en_round", 128'(rnd128), 128'd0);

      k128 = KEYA; ld128 = 1'b1;
      tick();
      ld128 = 1'b0;
      chk("r0_key", sk128, rk128[0]);
      chk("r0_round", 128'(rnd128), 128'd0);
      chk("r0_valid", 128'(v128), 128'd1);
      chk("r0_last", 128'(l128), 128'd0);

      en128 = 1'b1;
      tick();
      chk("r1_key", sk128, rk128[1]);
      chk("r1_round", 128'(rnd128), 128'd1);
      en128 = 1'b0;
      for (int g = 0; g < 2; g++) begin
         tick();
         chk("gap_key", sk128, rk128[1]);
         chk("gap_round", 128'(rnd128), 128'd1);
      end
      en128 = 1'b1;
      tick();
      chk("r2_key", sk128, rk128[2]);
      chk("r2_round", 128'(rnd128), 128'd2);
      for (int r = 3; r <= 10; r++) begin
         tick();
         chk($sformatf("r%0d_key", r), sk128, rk128[r]);
         chk($sformatf("r%0d_round", r), 128'(rnd128), 128'(r));
         chk($sformatf("r%0d_last", r), 128'(l128), 128'(r == 10));
      end
      chk("done_valid", 128'(v128), 128'd1);
      for (int d = 0; d < 3; d++) begin
         tick();
         chk("done_round", 128'(rnd128), 128'd10);
         chk("done_key", sk128, rk128[10]);
         chk("done_last", 128'(l128), 128'd1);
      end
      en128 = 1'b0;

`ifdef KEY_GEN_ROUND_CACHE_EN
      for (int a = 10; a >= 0; a--) begin
         rd_addr = 4'(a);
         tick();
         chk($sformatf("cache_key%0d", a), rd_key, rk128[a]);
         chk($sformatf("cache_ok%0d", a), 128'(rd_ok), 128'd1);
      end
      rd_addr = 4'd11;
      tick();
      chk("cache_oob_ok", 128'(rd_ok), 128'd0);
      chk("cache_oob_key", rd_key, 128'h0);
`endif

      k128 = KEYA; ld128 = 1'b1;
      tick();
      ld128 = 1'b0; en128 = 1'b1;
      repeat (5) tick();
      chk("mid_r5_round", 128'(rnd128), 128'd5);
      chk("mid_r5_key", sk128, rk128[5]);
      k128 = KEYB; ld128 = 1'b1;
      tick();
      ld128 = 1'b0; en128 = 1'b0;
      chk("reload_key", sk128, KEYB);
      chk("reload_round", 128'(rnd128), 128'd0);
      chk("reload_valid", 128'(v128), 128'd1);
      chk("reload_last", 128'(l128), 128'd0);
`ifdef KEY_GEN_ROUND_CACHE_EN
      rd_addr = 4'd1;
      tick();
      chk("cache_after_load_ok1", 128'(rd_ok), 128'd0);
`endif
      en128 = 1'b1;
      tick();
      en128 = 1'b0;
      chk("reload_r1_key", sk128, KEYB_R1);
      chk("reload_r1_round", 128'(rnd128), 128'd1);

      k192 = 192'h8E73B0F7DA0E6452C810F32B809079E562F8EAD2522C6B7B; ld192 = 1'b1;
      tick();
      ld192 = 1'b0;
      chk("k192_r0_key", sk192, 128'h8E73B0F7DA0E6452C810F32B809079E5);
      en192 = 1'b1;
      tick();
      chk("k192_r1_key", sk192, 128'h62F8EAD2522C6B7BFE0C91F72402F5A5);
      repeat (11) tick();
      en192 = 1'b0;
      chk("k192_r12_round", 128'(rnd192), 128'd12);
      chk("k192_r12_key", sk192, 128'hE98BA06F448C773C8ECC720401002202);
      chk("k192_r12_last", 128'(l192), 128'd1);

      k256 = 256'h603DEB1015CA71BE2B73AEF0857D77811F352C073B6108D72D9810A30914DFF4;
      ld256 = 1'b1;
      tick();
      ld256 = 1'b0;
      chk("k256_r0_key", sk256, 128'h603DEB1015CA71BE2B73AEF0857D7781);
      en256 = 1'b1;
      tick();
      chk("k256_r1_key", sk256, 128'h1F352C073B6108D72D9810A30914DFF4);
      tick();
      chk("k256_r2_key", sk256, 128'h9BA354118E6925AFA51A8B5F2067FCDE);
      repeat (12) tick();
      en256 = 1'b0;
      chk("k256_r14_round", 128'(rnd256), 128'd14);
      chk("k256_r14_key", sk256, 128'hFE4890D1E6188D0B046DF344706C631E);
      chk("k256_r14_last", 128'(l256), 128'd1);

      k128 = KEYA; ld128 = 1'b1;
      tick();
      ld128 = 1'b0; en128 = 1'b1;
      repeat (3) tick();
      en128 = 1'b0;
      chk("pre_rst_round", 128'(rnd128), 128'd3);
      chk("pre_rst_key", sk128, rk128[3]);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_key", sk128, 128'h0);
      chk("async_rst_round", 128'(rnd128), 128'd0);
      chk("async_rst_valid", 128'(v128), 128'd0);
      chk("async_rst_last", 128'(l128), 128'd0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
